mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 114 +++++++++++
 tb/tb_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory access controller: arbitrates the fetch and data ports onto one
// single-port byte-wide RAM, moving 1, 2 or 4 bytes per granted request.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        stall_req
);
  // state | meaning
  // IDLE  | arbitrate requests, data port wins over fetch
  // XFER  | stream bytes to/from the RAM
  // DONE  | pulse the ack of the granted port
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        port_mem, we;
  logic [31:0] base, wdata, result, assembled;
  logic [2:0]  n, cnt;
  logic        grant_mem, grant_if, last, issue;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          grant_mem = 1'b1;
          state_nxt = XFER;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        // reads need one extra cycle to capture the final RAM byte
        last = we ? (cnt == n - 3'd1) : (cnt == n);
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_mem  <= 1'b0;
      we        <= 1'b0;
      base      <= 32'd0;
      wdata     <= 32'd0;
      result    <= 32'd0;
      n         <= 3'd0;
      cnt       <= 3'd0;
      if_inst   <= 32'd0;
      mem_rdata <= 32'd0;
    end else if (grant_mem) begin
      port_mem <= 1'b1;
      we       <= mem_we;
      base     <= mem_addr;
      wdata    <= mem_wdata;
      n        <= (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
      cnt      <= 3'd0;
      result   <= 32'd0;
    end else if (grant_if) begin
      port_mem <= 1'b0;
      we       <= 1'b0;
      base     <= if_addr;
      wdata    <= 32'd0;
      n        <= 3'd4;
      cnt      <= 3'd0;
      result   <= 32'd0;
    end else if (state == XFER) begin
      cnt <= cnt + 3'd1;
      if (!we && cnt != 3'd0) result <= assembled;
      if (last && !we) begin
        if (port_mem) mem_rdata <= assembled;
        else          if_inst   <= assembled;
      end
    end
  end

  // RAM data for the address issued one cycle earlier lands in byte cnt-1
  assign assembled = result | ({24'd0, ram_din} << {cnt - 3'd1, 3'b000});

  assign issue     = (state == XFER) && (cnt < n);
  assign ram_addr  = issue ? base + {29'd0, cnt} : 32'd0;
  assign ram_wr    = issue & we;
  assign ram_dout  = ram_wr ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'd0;

  assign if_ack    = (state == DONE) && !port_mem;
  assign mem_ack   = (state == DONE) && port_mem;
  assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: RAM device, reference model, directed and
// randomized fetch/load/store traffic, reset mid-transfer.
module tb_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] if_addr = 32'd0, mem_addr = 32'd0, mem_wdata = 32'd0;
  logic [1:0]  mem_len = 2'd0;
  logic        if_ack, mem_ack, ram_wr, stall_req;
  logic [31:0] if_inst, mem_rdata, ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'd0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] addr; logic wr; logic [7:0] dout; } ev_t;
  typedef struct { bit is_mem; bit we; logic [31:0] data; int cyc; } sb_t;

  ev_t         evq[$];
  sb_t         sbq[$];
  logic [7:0]  dev_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  int          cyc = 0, vectors = 0, miscompares = 0;
  int          exp_if_ack = -1, exp_mem_ack = -1;
  logic [31:0] last_rdata = 32'd0, last_inst = 32'd0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_stall();
    return (if_req && cyc != exp_if_ack) || (mem_req && cyc != exp_mem_ack);
  endfunction

  // Reference: byte k of an n-byte access at base+k in cycle t+1+k,
  // store acks at t+1+n, load/fetch acks at t+2+n.
  function automatic int model_xfer(input bit is_mem, input int t, input logic [31:0] base,
                                    input bit we, input int n, input logic [31:0] wd);
    logic [31:0] rd, a;
    ev_t e;
    sb_t s;
    rd = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = base + 32'(k);
      e.cyc = t + 1 + k; e.addr = a; e.wr = we; e.dout = we ? wd[8*k +: 8] : 8'h00;
      evq.push_back(e);
      if (we) ref_mem[a[15:0]] = wd[8*k +: 8];
      else    rd[8*k +: 8] = ref_mem[a[15:0]];
    end
    s.is_mem = is_mem; s.we = we; s.data = rd; s.cyc = we ? t + 1 + n : t + 2 + n;
    sbq.push_back(s);
    return s.cyc;
  endfunction

  function automatic int len_n(input logic [1:0] l);
    return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
  endfunction

  // RAM device: 16 address bits decoded, 1-cycle read latency
  initial begin
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = init_byte(32'(i));
      ref_mem[i] = init_byte(32'(i));
    end
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      ram_din <= dev_mem[ram_addr[15:0]];
      if (ram_wr) dev_mem[ram_addr[15:0]] = ram_dout;
    end
  end

  // Monitor
  initial begin
    ev_t e;
    sb_t s;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("stall_req", 32'(stall_req), 32'(exp_stall()));
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          e = evq.pop_front();
          chk("ram_addr", ram_addr, e.addr);
          chk("ram_wr", 32'(ram_wr), 32'(e.wr));
          chk("ram_dout", 32'(ram_dout), 32'(e.dout));
        end else begin
          chk("ram_wr_idle", 32'(ram_wr), 32'd0);
          if (sbq.size() == 0) begin
            chk("ram_addr_idle", ram_addr, 32'd0);
            chk("ram_dout_idle", 32'(ram_dout), 32'd0);
          end
        end
        if (if_ack || mem_ack) begin
          if (sbq.size() == 0) chk("unexpected_ack", {30'd0, if_ack, mem_ack}, 32'd0);
          else begin
            s = sbq.pop_front();
            chk("ack_port", {30'd0, if_ack, mem_ack}, s.is_mem ? 32'd1 : 32'd2);
            chk("ack_cycle", 32'(cyc), 32'(s.cyc));
            if (!s.is_mem) begin
              chk("if_inst", if_inst, s.data);
              last_inst = s.data;
            end else if (!s.we) begin
              chk("mem_rdata", mem_rdata, s.data);
              last_rdata = s.data;
            end else chk("mem_rdata_hold", mem_rdata, last_rdata);
          end
        end else begin
          chk("mem_rdata_hold", mem_rdata, last_rdata);
          chk("if_inst_hold", if_inst, last_inst);
        end
      end
    end
  end

  // Called at posedge+1 of a cycle in which the controller sits in IDLE.
  task automatic run_job(input bit do_if, input bit do_mem, input logic [31:0] ia,
                         input bit mwe, input logic [31:0] ma, input logic [1:0] ml,
                         input logic [31:0] mw, input bit perturb);
    int t;
    bit pend_i, pend_m, gi, gm;
    t = cyc;
    if (do_mem) begin
      exp_mem_ack = model_xfer(1'b1, t, ma, mwe, len_n(ml), mw);
      t = exp_mem_ack + 1;
    end
    if (do_if) exp_if_ack = model_xfer(1'b0, t, ia, 1'b0, 4, 32'd0);
    if_addr = ia; mem_addr = ma; mem_we = mwe; mem_len = ml; mem_wdata = mw;
    if_req = do_if; mem_req = do_mem;
    pend_i = do_if; pend_m = do_mem;
    for (int i = 0; i < 40 && (pend_i || pend_m); i++) begin
      @(negedge clk);
      gi = if_ack; gm = mem_ack;
      @(posedge clk); #1;
      if (gi) begin if_req = 1'b0; pend_i = 1'b0; end
      if (gm) begin mem_req = 1'b0; pend_m = 1'b0; end
      if (perturb && (pend_i || pend_m)) begin
        if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
        mem_we = 1'($urandom); mem_len = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin if_req = 1'b0; mem_req = 1'b0; end
      end
    end
    if (pend_i || pend_m) chk("ack_timeout", {30'd0, pend_i, pend_m}, 32'd0);
    exp_if_ack = -1; exp_mem_ack = -1;
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? $urandom : 32'h400 + 32'($urandom_range(0, 31));
  endfunction

  initial begin
    int kind;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_mem_ack", 32'(mem_ack), 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    {dev_mem[16'h100], dev_mem[16'h101], dev_mem[16'h102], dev_mem[16'h103]} = 32'h13050000;
    {ref_mem[16'h100], ref_mem[16'h101], ref_mem[16'h102], ref_mem[16'h103]} = 32'h13050000;
    run_job(1'b1, 1'b0, 32'h100, 1'b0, 32'd0, 2'b00, 32'd0, 1'b0);
    chk("fetch_inst", if_inst, 32'h00000513);
    run_job(1'b0, 1'b1, 32'd0, 1'b1, 32'h200, 2'b10, 32'hDEADBEEF, 1'b0);
    run_job(1'b0, 1'b1, 32'd0, 1'b0, 32'h203, 2'b00, 32'd0, 1'b0);
    chk("byte_load", mem_rdata, 32'h000000DE);
    run_job(1'b1, 1'b1, 32'h100, 1'b0, 32'h200, 2'b01, 32'd0, 1'b0);
    chk("contend_half", mem_rdata, 32'h0000BEEF);
    chk("contend_inst", if_inst, 32'h00000513);
    run_job(1'b0, 1'b1, 32'd0, 1'b0, 32'hFFFFFFFE, 2'b10, 32'd0, 1'b0);

    for (int j = 0; j < 150; j++) begin
      kind = $urandom_range(0, 2);
      run_job(kind != 1, kind != 0, rnd_addr(), 1'($urandom), rnd_addr(), 2'($urandom),
              $urandom, (kind != 2) && ($urandom_range(0, 1) == 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset after two bytes of a word store have been written
    begin
      ev_t e;
      e.cyc = cyc + 1; e.addr = 32'h340; e.wr = 1'b1; e.dout = 8'hD4; evq.push_back(e);
      e.cyc = cyc + 2; e.addr = 32'h341; e.wr = 1'b1; e.dout = 8'hC3; evq.push_back(e);
      ref_mem[16'h340] = 8'hD4; ref_mem[16'h341] = 8'hC3;
      mem_addr = 32'h340; mem_we = 1'b1; mem_len = 2'b10; mem_wdata = 32'hA1B2C3D4;
      mem_req = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0; mem_req = 1'b0; last_rdata = 32'd0; last_inst = 32'd0;
      @(negedge clk);
      chk("mid_rst_ram_wr", 32'(ram_wr), 32'd0);
      chk("mid_rst_ram_addr", ram_addr, 32'd0);
      chk("mid_rst_ram_dout", 32'(ram_dout), 32'd0);
      chk("mid_rst_mem_ack", 32'(mem_ack), 32'd0);
      chk("mid_rst_mem_rdata", mem_rdata, 32'd0);
      chk("mid_rst_if_inst", if_inst, 32'd0);
      chk("mid_rst_evq", 32'(evq.size()), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
    end
    run_job(1'b0, 1'b1, 32'd0, 1'b0, 32'h340, 2'b10, 32'd0, 1'b0);
    chk("partial_store", mem_rdata,
        {init_byte(32'h343), init_byte(32'h342), 8'hC3, 8'hD4});
    run_job(1'b0, 1'b1, 32'd0, 1'b1, 32'h340, 2'b10, 32'hA1B2C3D4, 1'b0);
    run_job(1'b0, 1'b1, 32'd0, 1'b0, 32'h340, 2'b10, 32'd0, 1'b0);
    chk("reissued_store", mem_rdata, 32'hA1B2C3D4);

    repeat (4) begin @(posedge clk); #1; end
    chk("sbq_drained", 32'(sbq.size()), 32'd0);
    chk("evq_drained", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
    $fatal(1);
  end
endmodule
